// File: rtl/tempo_para_segundos.sv
// Converts year/month/day/hour/minute/second fields into a total second count.
// One weighted term per clock through a single shared multiplier; result saturates on overflow.
module tempo_para_segundos #(
  parameter int WIDTH    = 32,
  parameter int SEG_MIN  = 60,
  parameter int SEG_HORA = 3600,
  parameter int SEG_DIA  = 86400,
  parameter int SEG_MES  = 2592000,
  parameter int SEG_ANO  = 31536000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] anos,
  input  logic [WIDTH-1:0] mes,
  input  logic [WIDTH-1:0] dias,
  input  logic [WIDTH-1:0] horas,
  input  logic [WIDTH-1:0] minutos,
  input  logic [WIDTH-1:0] segundos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] total_seg,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only while a finished result is held in DONE.

  localparam int ACC_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     fld_q [6];
  logic [WIDTH-1:0]     fld_d [6];
  logic [WIDTH-1:0]     total_q, total_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     weight;
  logic [ACC_W-1:0]     prod;
  logic                 sum_ovf;

  // Operand/weight select for the shared multiplier.
  always_comb begin
    opnd   = '0;
    weight = '0;
    case (step_q)
      3'd0: begin opnd = fld_q[0]; weight = WIDTH'(SEG_ANO);  end
      3'd1: begin opnd = fld_q[1]; weight = WIDTH'(SEG_MES);  end
      3'd2: begin opnd = fld_q[2]; weight = WIDTH'(SEG_DIA);  end
      3'd3: begin opnd = fld_q[3]; weight = WIDTH'(SEG_HORA); end
      3'd4: begin opnd = fld_q[4]; weight = WIDTH'(SEG_MIN);  end
      3'd5: begin opnd = fld_q[5]; weight = WIDTH'(1);        end
      default: begin opnd = '0; weight = '0; end
    endcase
  end

  assign prod    = ACC_W'(opnd) * ACC_W'(weight);
  assign sum_ovf = |acc_q[ACC_W-1:WIDTH];

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    fld_d       = fld_q;
    total_d     = total_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fld_d[0] = anos;
          fld_d[1] = mes;
          fld_d[2] = dias;
          fld_d[3] = horas;
          fld_d[4] = minutos;
          fld_d[5] = segundos;
          acc_d    = '0;
          step_d   = '0;
          state_d  = ACC;
        end
      end
      ACC: begin
        acc_d  = acc_q + prod;
        step_d = step_q + 3'd1;
        if (step_q == 3'd5) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle registers the result; afterwards it is held until taken.
        if (!out_valid_q) begin
          total_d     = sum_ovf ? '1 : acc_q[WIDTH-1:0];
          ovf_d       = sum_ovf;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      total_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 6; i++) fld_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      total_q     <= total_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 6; i++) fld_q[i] <= fld_d[i];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign total_seg = total_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tempo_para_segundos.sv
// Directed bench for tempo_para_segundos: latency, round trip, overflow boundary,
// backpressure and mid-operation reset, with hand-computed expected totals.
module tb_tempo_para_segundos;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] anos, mes, dias, horas, minutos, segundos;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] total_seg;
  logic         ovf;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];

  tempo_para_segundos dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .anos      (anos),
    .mes       (mes),
    .dias      (dias),
    .horas     (horas),
    .minutos   (minutos),
    .segundos  (segundos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .total_seg (total_seg),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [W-1:0] a, input logic [W-1:0] m, input logic [W-1:0] d,
                            input logic [W-1:0] h, input logic [W-1:0] mi, input logic [W-1:0] s);
    anos = a; mes = m; dias = d; horas = h; minutos = mi; segundos = s;
  endtask

  // Accept one set of fields, check exact latency, then compare against the expected queue.
  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] m,
                     input logic [W-1:0] d, input logic [W-1:0] h, input logic [W-1:0] mi,
                     input logic [W-1:0] s, input logic [W-1:0] exp_tot, input logic exp_ovf);
    logic [W:0] e;
    exp_q.push_back({exp_ovf, exp_tot});
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    set_fields(a, m, d, h, mi, s);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_fields('1, '1, '1, '1, '1, '1);
    for (int i = 0; i < 6; i++) tick();
    check({tag, ".early_valid"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    e = exp_q.pop_front();
    check({tag, ".total"}, 64'(total_seg), 64'(e[W-1:0]));
    check({tag, ".ovf"}, 64'(ovf), 64'(e[W]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".release"}, 64'(out_valid), 64'd0);
    check({tag, ".hold_total"}, 64'(total_seg), 64'(e[W-1:0]));
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    set_fields(1, 1, 1, 1, 1, 1);

    // Reset with in_valid asserted: nothing may be accepted.
    tick();
    tick();
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.total", 64'(total_seg), 64'd0);
    check("rst.ovf", 64'(ovf), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst.in_ready", 64'(in_ready), 64'd1);

    run("ones", 1, 1, 1, 1, 1, 1, 32'd34218061, 1'b0);
    run("round", 3, 2, 2, 9, 46, 40, 32'd100000000, 1'b0);
    run("y136", 136, 0, 0, 0, 0, 0, 32'd4288896000, 1'b0);
    run("y137", 137, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b1);
    run("edge", 136, 0, 0, 0, 0, 6071295, 32'hFFFF_FFFF, 1'b0);
    run("min75", 0, 0, 0, 0, 75, 0, 32'd4500, 1'b0);

    // Backpressure: result waits while new fields are offered.
    set_fields(0, 0, 0, 2, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("bp.out_valid", 64'(out_valid), 64'd1);
    check("bp.total", 64'(total_seg), 64'd7200);
    set_fields(0, 0, 0, 1, 0, 5);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.stall_total", 64'(total_seg), 64'd7200);
      check("bp.stall_in_ready", 64'(in_ready), 64'd0);
      check("bp.stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.idle_valid", 64'(out_valid), 64'd0);
    check("bp.idle_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp.accepted", 64'(in_ready), 64'd0);
    for (int i = 0; i < 7; i++) tick();
    check("bp.new_valid", 64'(out_valid), 64'd1);
    check("bp.new_total", 64'(total_seg), 64'd3605);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of accumulation drops the conversion.
    set_fields(0, 0, 0, 0, 0, 59);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.in_ready", 64'(in_ready), 64'd1);
    check("mid_rst.total", 64'(total_seg), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_rst.no_valid", 64'(seen), 64'd0);
    run("after_rst", 0, 0, 0, 0, 0, 59, 32'd59, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
